// File: rtl/i2c_apb_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_apb_master_if
//  Description : Bundle of the command, response and APB signals of
//                i2c_apb_master.
//                master modport : the i2c_apb_master side (drives APB + rsp)
//                slave modport  : the requester / APB target side
//                Signals:
//                  cmd_valid_i/cmd_ready_o/cmd_write_i/cmd_addr_i/cmd_wdata_i
//                  rsp_valid_o/rsp_ready_i/rsp_rdata_o/rsp_error_o, busy_o
//                  psel_o/penable_o/pwrite_o/paddr_o/pwdata_o/prdata_i/pready_i
//  Revision    : 1.0 - initial release
// ============================================================================
interface i2c_apb_master_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  // Command channel
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic                  cmd_write_i;
  logic [ADDR_WIDTH-1:0] cmd_addr_i;
  logic [DATA_WIDTH-1:0] cmd_wdata_i;
  // Response channel
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic                  rsp_error_o;
  logic                  busy_o;
  // APB initiator
  logic                  psel_o;
  logic                  penable_o;
  logic                  pwrite_o;
  logic [ADDR_WIDTH-1:0] paddr_o;
  logic [DATA_WIDTH-1:0] pwdata_o;
  logic [DATA_WIDTH-1:0] prdata_i;
  logic                  pready_i;

  modport master (
    input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
    input  rsp_ready_i, prdata_i, pready_i,
    output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o, busy_o,
    output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
  );

  modport slave (
    output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
    output rsp_ready_i, prdata_i, pready_i,
    input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o, busy_o,
    input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
  );
endinterface
`default_nettype wire

// File: rtl/i2c_apb_master.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_apb_master
//  Description : Single-command APB initiator for the I2C master register
//                block. Each accepted command runs one APB transfer
//                (SETUP then ACCESS) and returns one response. The ACCESS
//                phase is aborted with rsp_error_o after TIMEOUT_CYCLES
//                cycles of pready_i low (TIMEOUT_CYCLES = 0 waits forever).
//  Ports       : pclk_i      - clock, rising edge
//                preset_n_i  - asynchronous active-low reset
//                bus         - i2c_apb_master_if.master (cmd, rsp, APB)
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_apb_master #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  wire logic         pclk_i,
  input  wire logic         preset_n_i,
  i2c_apb_master_if.master  bus
);

  // Counter must hold TIMEOUT_CYCLES-1 without wrapping.
  localparam int c_cnt_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit c_to_en = (TIMEOUT_CYCLES != 0);
  localparam logic [c_cnt_w-1:0] c_cnt_last =
    (TIMEOUT_CYCLES > 0) ? c_cnt_w'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_psel, w_psel_nxt;
  logic                  r_penable, w_penable_nxt;
  logic                  r_pwrite, w_pwrite_nxt;
  logic [ADDR_WIDTH-1:0] r_paddr, w_paddr_nxt;
  logic [DATA_WIDTH-1:0] r_pwdata, w_pwdata_nxt;
  logic                  r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic                  r_rsp_error, w_rsp_error_nxt;
  logic [c_cnt_w-1:0]    r_cnt, w_cnt_nxt;

  // State register
  always_ff @(posedge pclk_i or negedge preset_n_i) begin
    if (!preset_n_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt     = r_state;
    w_psel_nxt      = r_psel;
    w_penable_nxt   = r_penable;
    w_pwrite_nxt    = r_pwrite;
    w_paddr_nxt     = r_paddr;
    w_pwdata_nxt    = r_pwdata;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_error_nxt = r_rsp_error;
    w_cnt_nxt       = r_cnt;

    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid_i) begin
          w_paddr_nxt   = bus.cmd_addr_i;
          w_pwrite_nxt  = bus.cmd_write_i;
          // Reads drive a clean zero on pwdata rather than stale data.
          w_pwdata_nxt  = bus.cmd_write_i ? bus.cmd_wdata_i : '0;
          w_psel_nxt    = 1'b1;
          w_penable_nxt = 1'b0;
          w_state_nxt   = S_SETUP;
        end
      end

      S_SETUP: begin
        w_penable_nxt = 1'b1;
        w_cnt_nxt     = '0;
        w_state_nxt   = S_ACCESS;
      end

      S_ACCESS: begin
        if (bus.pready_i) begin
          w_psel_nxt      = 1'b0;
          w_penable_nxt   = 1'b0;
          w_rsp_rdata_nxt = r_pwrite ? '0 : bus.prdata_i;
          w_rsp_error_nxt = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = S_RESP;
        end else if (c_to_en && (r_cnt == c_cnt_last)) begin
          w_psel_nxt      = 1'b0;
          w_penable_nxt   = 1'b0;
          w_rsp_rdata_nxt = '0;
          w_rsp_error_nxt = 1'b1;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = S_RESP;
        end else if (c_to_en) begin
          w_cnt_nxt = r_cnt + c_cnt_w'(1);
        end
      end

      S_RESP: begin
        // rdata/error are left untouched so they stay readable after the
        // handshake until the next response overwrites them.
        if (bus.rsp_ready_i) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered outputs and timeout counter
  always_ff @(posedge pclk_i or negedge preset_n_i) begin
    if (!preset_n_i) begin
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_error <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_pwrite    <= w_pwrite_nxt;
      r_paddr     <= w_paddr_nxt;
      r_pwdata    <= w_pwdata_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_error <= w_rsp_error_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  assign bus.cmd_ready_o = (r_state == S_IDLE);
  assign bus.busy_o      = (r_state != S_IDLE);
  assign bus.psel_o      = r_psel;
  assign bus.penable_o   = r_penable;
  assign bus.pwrite_o    = r_pwrite;
  assign bus.paddr_o     = r_paddr;
  assign bus.pwdata_o    = r_pwdata;
  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_rdata_o = r_rsp_rdata;
  assign bus.rsp_error_o = r_rsp_error;

endmodule
`default_nettype wire

// File: tb/tb_i2c_apb_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_apb_master
//  Description : Directed self-checking bench for i2c_apb_master. One DUT
//                uses TIMEOUT_CYCLES=16, a second uses TIMEOUT_CYCLES=0.
//                Inputs change 1 ns after a rising edge; outputs are checked
//                at the same point, i.e. away from the active edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_apb_master;

  logic pclk_i;
  logic preset_n_i;
  int   checks;
  int   errors;

  i2c_apb_master_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus  ();
  i2c_apb_master_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus0 ();

  i2c_apb_master #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
    .pclk_i     (pclk_i),
    .preset_n_i (preset_n_i),
    .bus        (bus)
  );

  i2c_apb_master #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .TIMEOUT_CYCLES(0)) dut0 (
    .pclk_i     (pclk_i),
    .preset_n_i (preset_n_i),
    .bus        (bus0)
  );

  initial pclk_i = 1'b0;
  always #5 pclk_i = ~pclk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk_i);
    #1;
  endtask

  task automatic cmd(input logic wr, input logic [7:0] addr, input logic [7:0] data);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_write_i = wr;
    bus.cmd_addr_i  = addr;
    bus.cmd_wdata_i = data;
  endtask

  logic [7:0] addrs [4];

  initial begin
    checks = 0;
    errors = 0;
    addrs[0] = 8'h00; addrs[1] = 8'h01; addrs[2] = 8'h02; addrs[3] = 8'h04;

    bus.cmd_valid_i  = 1'b0; bus.cmd_write_i  = 1'b0; bus.cmd_addr_i  = '0; bus.cmd_wdata_i  = '0;
    bus.rsp_ready_i  = 1'b0; bus.prdata_i     = '0;   bus.pready_i    = 1'b0;
    bus0.cmd_valid_i = 1'b0; bus0.cmd_write_i = 1'b0; bus0.cmd_addr_i = '0; bus0.cmd_wdata_i = '0;
    bus0.rsp_ready_i = 1'b0; bus0.prdata_i    = '0;   bus0.pready_i   = 1'b0;

    // ---------------- Reset state ----------------
    preset_n_i = 1'b0;
    tick(); tick();
    chk("rst_psel",      bus.psel_o,      0);
    chk("rst_penable",   bus.penable_o,   0);
    chk("rst_paddr",     bus.paddr_o,     0);
    chk("rst_pwdata",    bus.pwdata_o,    0);
    chk("rst_rsp_valid", bus.rsp_valid_o, 0);
    chk("rst_rsp_error", bus.rsp_error_o, 0);
    chk("rst_busy",      bus.busy_o,      0);
    preset_n_i = 1'b1;
    tick();
    chk("rst_cmd_ready", bus.cmd_ready_o, 1);

    // ---------------- Write, zero wait ----------------
    bus.pready_i = 1'b1;
    cmd(1'b1, 8'h00, 8'h3C);
    tick();                                   // accept edge N -> SETUP
    chk("wr_setup_psel",    bus.psel_o,      1);
    chk("wr_setup_penable", bus.penable_o,   0);
    chk("wr_setup_busy",    bus.busy_o,      1);
    chk("wr_setup_ready",   bus.cmd_ready_o, 0);
    bus.cmd_valid_i = 1'b0;
    tick();                                   // ACCESS
    chk("wr_acc_psel",    bus.psel_o,    1);
    chk("wr_acc_penable", bus.penable_o, 1);
    chk("wr_acc_paddr",   bus.paddr_o,   8'h00);
    chk("wr_acc_pwdata",  bus.pwdata_o,  8'h3C);
    chk("wr_acc_pwrite",  bus.pwrite_o,  1);
    chk("wr_acc_rspv",    bus.rsp_valid_o, 0);
    tick();                                   // RESP, 3 cycles after accept
    chk("wr_rsp_valid", bus.rsp_valid_o, 1);
    chk("wr_rsp_error", bus.rsp_error_o, 0);
    chk("wr_rsp_rdata", bus.rsp_rdata_o, 8'h00);
    chk("wr_rsp_psel",  bus.psel_o,      0);
    bus.rsp_ready_i = 1'b1;
    tick();
    chk("wr_done_valid", bus.rsp_valid_o, 0);
    chk("wr_done_ready", bus.cmd_ready_o, 1);
    bus.rsp_ready_i = 1'b0;

    // ---------------- Read with 3 wait states ----------------
    bus.pready_i = 1'b0;
    cmd(1'b0, 8'h05, 8'hFF);
    tick();                                   // SETUP
    chk("rd_setup_pwdata", bus.pwdata_o, 8'h00);
    chk("rd_setup_pwrite", bus.pwrite_o, 0);
    bus.cmd_valid_i = 1'b0;
    bus.cmd_addr_i  = 8'hEE;                  // must not affect latched address
    bus.cmd_write_i = 1'b1;
    for (int i = 0; i < 4; i++) begin         // ACCESS cycles 1..4
      tick();
      chk("rd_acc_penable", bus.penable_o,   1);
      chk("rd_acc_rspv",    bus.rsp_valid_o, 0);
    end
    chk("rd_acc_paddr",  bus.paddr_o,  8'h05);
    chk("rd_acc_pwdata", bus.pwdata_o, 8'h00);
    chk("rd_acc_pwrite", bus.pwrite_o, 0);
    bus.pready_i = 1'b1;
    bus.prdata_i = 8'hA5;
    tick();
    chk("rd_rsp_valid", bus.rsp_valid_o, 1);
    chk("rd_rsp_rdata", bus.rsp_rdata_o, 8'hA5);
    chk("rd_rsp_error", bus.rsp_error_o, 0);
    bus.prdata_i = 8'h11;                     // ignored in RESP

    // ---------------- Response backpressure ----------------
    cmd(1'b1, 8'h02, 8'h77);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_rsp_valid", bus.rsp_valid_o, 1);
      chk("bp_rsp_rdata", bus.rsp_rdata_o, 8'hA5);
      chk("bp_cmd_ready", bus.cmd_ready_o, 0);
      chk("bp_psel",      bus.psel_o,      0);
    end
    bus.rsp_ready_i = 1'b1;
    tick();                                   // handshake -> IDLE
    chk("bp_hs_valid",  bus.rsp_valid_o, 0);
    chk("bp_hs_ready",  bus.cmd_ready_o, 1);
    chk("bp_hs_psel",   bus.psel_o,      0);
    chk("bp_hs_rdata",  bus.rsp_rdata_o, 8'hA5);
    bus.rsp_ready_i = 1'b0;
    tick();                                   // next command accepted
    chk("bp_next_psel",  bus.psel_o,  1);
    chk("bp_next_paddr", bus.paddr_o, 8'h02);
    bus.cmd_valid_i = 1'b0;
    tick(); tick();
    chk("bp_next_rspv",  bus.rsp_valid_o, 1);
    chk("bp_next_rdata", bus.rsp_rdata_o, 8'h00);
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;

    // ---------------- Timeout (16 cycles) ----------------
    bus.pready_i = 1'b0;
    bus.prdata_i = 8'hC3;
    cmd(1'b0, 8'h07, 8'h00);
    tick();                                   // SETUP
    bus.cmd_valid_i = 1'b0;
    for (int i = 0; i < 16; i++) begin        // ACCESS cycles 1..16
      tick();
      chk("to_acc_penable", bus.penable_o,   1);
      chk("to_acc_rspv",    bus.rsp_valid_o, 0);
    end
    tick();
    chk("to_rsp_valid", bus.rsp_valid_o, 1);
    chk("to_rsp_error", bus.rsp_error_o, 1);
    chk("to_rsp_rdata", bus.rsp_rdata_o, 8'h00);
    chk("to_psel",      bus.psel_o,      0);
    chk("to_penable",   bus.penable_o,   0);
    bus.rsp_ready_i = 1'b1;
    tick();
    chk("to_done_ready", bus.cmd_ready_o, 1);
    bus.rsp_ready_i = 1'b0;

    // ---------------- Timeout disabled (second instance) ----------------
    bus0.cmd_valid_i = 1'b1;
    bus0.cmd_write_i = 1'b0;
    bus0.cmd_addr_i  = 8'h03;
    tick();                                   // SETUP
    bus0.cmd_valid_i = 1'b0;
    for (int i = 0; i < 40; i++) tick();      // 40 ACCESS cycles, pready low
    chk("nto_penable", bus0.penable_o,   1);
    chk("nto_rspv",    bus0.rsp_valid_o, 0);
    bus0.pready_i = 1'b1;
    bus0.prdata_i = 8'h5A;
    tick();
    chk("nto_rsp_valid", bus0.rsp_valid_o, 1);
    chk("nto_rsp_error", bus0.rsp_error_o, 0);
    chk("nto_rsp_rdata", bus0.rsp_rdata_o, 8'h5A);
    bus0.rsp_ready_i = 1'b1;
    tick();
    bus0.rsp_ready_i = 1'b0;
    bus0.pready_i    = 1'b0;

    // ---------------- Reset mid-transfer ----------------
    bus.pready_i = 1'b0;
    cmd(1'b1, 8'h09, 8'h42);
    tick();                                   // SETUP
    bus.cmd_valid_i = 1'b0;
    tick();                                   // ACCESS
    chk("mr_pre_penable", bus.penable_o, 1);
    #2 preset_n_i = 1'b0;
    #1;
    chk("mr_psel",    bus.psel_o,    0);
    chk("mr_penable", bus.penable_o, 0);
    chk("mr_busy",    bus.busy_o,    0);
    tick();
    preset_n_i   = 1'b1;
    bus.pready_i = 1'b1;                      // would finish a stale transfer
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mr_post_rspv",  bus.rsp_valid_o, 0);
      chk("mr_post_ready", bus.cmd_ready_o, 1);
      chk("mr_post_psel",  bus.psel_o,      0);
    end

    // ---------------- Back-to-back stream ----------------
    bus.rsp_ready_i = 1'b1;
    bus.pready_i    = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cmd(1'b1, addrs[k], 8'h10 + 8'(k));
      tick();                                 // accept
      chk("bb_setup_psel",    bus.psel_o,    1);
      chk("bb_setup_penable", bus.penable_o, 0);
      chk("bb_setup_paddr",   bus.paddr_o,   addrs[k]);
      tick();                                 // ACCESS
      chk("bb_acc_penable", bus.penable_o, 1);
      chk("bb_acc_pwdata",  bus.pwdata_o,  8'h10 + 8'(k));
      tick();                                 // RESP
      chk("bb_rsp_valid", bus.rsp_valid_o, 1);
      tick();                                 // IDLE cycle
      chk("bb_idle_ready", bus.cmd_ready_o, 1);
      chk("bb_idle_psel",  bus.psel_o,      0);
    end
    bus.cmd_valid_i = 1'b0;
    tick();
    chk("bb_end_psel",  bus.psel_o, 0);
    chk("bb_end_busy",  bus.busy_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_apb_master.md
Name: i2c_apb_master

Overview:
- APB initiator that drives the I2C master's APB register block, e.g. from a test sequencer or a small embedded controller.
- Accepts single register commands over a valid/ready interface and runs one APB transfer per command: SETUP phase, then ACCESS phase.
- Returns read data or an error over a valid/ready response interface.
- Bounds each ACCESS phase with a pready timeout.

Parameters:
- ADDR_WIDTH, 8, width of cmd_addr_i and paddr_o.
- DATA_WIDTH, 8, width of all data paths.
- TIMEOUT_CYCLES, 16, maximum number of consecutive ACCESS cycles with pready_i low before abort. Value 0 disables the timeout.

Ports:
- pclk_i  in  1  clock, rising edge.
- preset_n_i  in  1  reset.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  command accepted when high together with cmd_valid_i.
- cmd_write_i  in  1  1 = write, 0 = read.
- cmd_addr_i  in  ADDR_WIDTH  register address.
- cmd_wdata_i  in  DATA_WIDTH  write data.
- rsp_valid_o  out  1  response available.
- rsp_ready_i  in  1  response consumed.
- rsp_rdata_o  out  DATA_WIDTH  read data; 0 for writes and for errors.
- rsp_error_o  out  1  transfer aborted by timeout.
- busy_o  out  1  high in every state except IDLE.
- psel_o  out  1  APB select.
- penable_o  out  1  APB enable.
- pwrite_o  out  1  APB direction.
- paddr_o  out  ADDR_WIDTH  APB address.
- pwdata_o  out  DATA_WIDTH  APB write data.
- prdata_i  in  DATA_WIDTH  APB read data.
- pready_i  in  1  APB ready.

Behaviour:
- One clock, pclk_i. Reset is asynchronous and active-low on preset_n_i.
- Reset values:
  - State is IDLE.
  - psel_o, penable_o, pwrite_o, paddr_o, pwdata_o are 0.
  - rsp_valid_o, rsp_rdata_o, rsp_error_o, busy_o are 0.
  - Timeout counter is 0.
- All APB and rsp outputs are registered. cmd_ready_o = (state == IDLE), decoded from the state register.
- IDLE:
  - When cmd_valid_i is high, the command is accepted on that edge.
  - paddr_o <= cmd_addr_i, pwrite_o <= cmd_write_i, pwdata_o <= cmd_wdata_i for writes and 0 for reads.
  - psel_o <= 1, penable_o <= 0. Go to SETUP.
- SETUP (exactly one cycle):
  - penable_o <= 1, timeout counter <= 0. Go to ACCESS.
- ACCESS:
  - psel_o, penable_o, paddr_o, pwrite_o, pwdata_o are held stable.
  - If pready_i is sampled 1:
    - psel_o <= 0, penable_o <= 0.
    - rsp_rdata_o <= prdata_i for reads, 0 for writes.
    - rsp_error_o <= 0, rsp_valid_o <= 1. Go to RESP.
  - Else, if TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1:
    - psel_o <= 0, penable_o <= 0.
    - rsp_rdata_o <= 0, rsp_error_o <= 1, rsp_valid_o <= 1. Go to RESP.
  - Else counter increments. The counter is wide enough for TIMEOUT_CYCLES without wrap.
- RESP:
  - rsp_valid_o, rsp_rdata_o, rsp_error_o are held until rsp_ready_i is sampled 1.
  - Then rsp_valid_o <= 0 and go to IDLE. rsp_rdata_o and rsp_error_o keep their values until the next response.
- Latency with zero wait states:
  - Accept at edge N; SETUP visible after edge N; ACCESS after N+1.
  - rsp_valid_o rises after N+2, i.e. 3 cycles from accept to rsp_valid_o.
  - Minimum command-to-command spacing is 4 cycles, counting one IDLE cycle.
- Commands presented outside IDLE are not accepted (cmd_ready_o = 0). No queuing; the requester holds cmd_valid_i.
- The command fields are latched at accept. Changes on cmd_* inputs during a transfer have no effect.
- Reset asserted in any state:
  - All outputs go to reset values immediately (asynchronous).
  - An in-flight APB transfer is dropped and no response is produced.
- pready_i and prdata_i are ignored in IDLE, SETUP and RESP.

Test Plan:
- Write, zero wait: cmd write addr 0x00 data 0x3C, pready_i tied 1 -> psel_o=1/penable_o=0 for 1 cycle, then psel_o=1/penable_o=1 for 1 cycle with paddr_o=0x00, pwdata_o=0x3C, pwrite_o=1; rsp_valid_o=1, rsp_error_o=0, rsp_rdata_o=0 three cycles after accept.
- Read with waits: cmd read addr 0x05; pready_i low 3 ACCESS cycles, then high with prdata_i=0xA5 -> ACCESS lasts 4 cycles; rsp_rdata_o=0xA5, rsp_error_o=0; pwdata_o=0 throughout.
- Response backpressure: rsp_ready_i low 5 cycles after rsp_valid_o, with cmd_valid_i high carrying the next command -> rsp_valid_o and data stable for 5 cycles; cmd_ready_o=0; next command accepted only in the cycle after the response handshake.
- Timeout: TIMEOUT_CYCLES=16, pready_i held 0 -> abort after exactly 16 ACCESS cycles; psel_o=0; rsp_error_o=1, rsp_rdata_o=0. With TIMEOUT_CYCLES=0 and pready_i released after 40 cycles -> normal completion, no error.
- Reset mid-transfer: assert preset_n_i low between clock edges during ACCESS -> psel_o, penable_o, busy_o drop immediately; after release cmd_ready_o=1 and no rsp_valid_o appears.
- Back-to-back stream: 4 writes to 0x00, 0x01, 0x02, 0x04 with rsp_ready_i tied 1 and pready_i tied 1 -> each transfer spaced 4 cycles; APB address sequence matches; no command dropped or duplicated.
